// File: rtl/manejo_memoria.sv
// Pending-request memory for a 4-floor elevator: latches call codes and, on
// obtener, registers the next move command derived from floor/direction/doors.
module manejo_memoria (
  input  logic       clk,
  input  logic       rst,
  input  logic       agregar,
  input  logic       obtener,
  input  logic       puertas_m,
  input  logic [1:0] accion_m,
  input  logic [1:0] piso_m,
  input  logic [3:0] boton_pres,
  output logic [3:0] memoria
);

  // Bit i of the pending vector holds code i+1.
  logic [9:0] pend_reg;
  logic [9:0] pend_cl;
  logic [9:0] pend_next;
  logic [3:0] sel;

  logic go_up, go_dn, compat_up, compat_dn;
  assign go_up     = (accion_m == 2'd1);
  assign go_dn     = (accion_m == 2'd2);
  assign compat_up = !go_dn;
  assign compat_dn = !go_up;

  logic [3:0] cab, up, dn, any, clr;
  logic [3:0] floor_code [4];
  logic [3:0] here_code  [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_floor
      assign clr[gi]     = puertas_m && (piso_m == 2'(gi));
      assign pend_cl[gi] = pend_reg[gi] && !clr[gi];
      assign cab[gi]     = pend_cl[gi];
      if (gi < 3) begin : g_up
        assign pend_cl[4+2*gi] = pend_reg[4+2*gi] && !(clr[gi] && compat_up);
        assign up[gi]          = pend_cl[4+2*gi];
      end else begin : g_no_up
        assign up[gi] = 1'b0;
      end
      if (gi > 0) begin : g_dn
        assign pend_cl[3+2*gi] = pend_reg[3+2*gi] && !(clr[gi] && compat_dn);
        assign dn[gi]          = pend_cl[3+2*gi];
      end else begin : g_no_dn
        assign dn[gi] = 1'b0;
      end
      assign any[gi] = cab[gi] | up[gi] | dn[gi];
      assign floor_code[gi] = cab[gi] ? 4'(gi + 1) :
                              up[gi]  ? 4'(5 + 2*gi) :
                              dn[gi]  ? 4'(4 + 2*gi) : 4'd0;
      // At the current floor only direction-compatible hall calls qualify.
      assign here_code[gi]  = cab[gi]              ? 4'(gi + 1) :
                              (up[gi] && compat_up) &&
                              !(go_dn)             ? 4'(5 + 2*gi) :
                              (dn[gi] && compat_dn) ? 4'(4 + 2*gi) : 4'd0;
    end
  endgenerate

  logic [3:0] here, above, below;

  always_comb begin
    here  = here_code[piso_m];
    above = 4'd0;
    below = 4'd0;
    // Descending/ascending scans leave the nearest floor's code last.
    for (int f = 3; f >= 0; f--) begin
      if (f > int'(piso_m) && any[f]) above = floor_code[f];
    end
    for (int f = 0; f < 4; f++) begin
      if (f < int'(piso_m) && any[f]) below = floor_code[f];
    end
    if (!puertas_m && here != 4'd0)   sel = here;
    else if (!go_dn && above != 4'd0) sel = above;
    else if (below != 4'd0)           sel = below;
    else if (go_dn && above != 4'd0)  sel = above;
    else                              sel = 4'd0;
  end

  // The door clear is applied before the new set so a fresh request survives.
  always_comb begin
    pend_next = obtener ? pend_cl : pend_reg;
    if (agregar && boton_pres >= 4'd1 && boton_pres <= 4'd10)
      pend_next[boton_pres - 4'd1] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_reg <= 10'd0;
      memoria  <= 4'd0;
    end else begin
      pend_reg <= pend_next;
      if (obtener) memoria <= sel;
    end
  end

endmodule

// File: tb/tb_manejo_memoria.sv
// Directed table-driven bench for manejo_memoria plus an async-reset sequence.
module tb_manejo_memoria;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       agregar = 1'b0;
  logic       obtener = 1'b0;
  logic       puertas_m = 1'b0;
  logic [1:0] accion_m = 2'd0;
  logic [1:0] piso_m = 2'd0;
  logic [3:0] boton_pres = 4'd0;
  logic [3:0] memoria;

  always #5 clk = ~clk;

  manejo_memoria dut (
    .clk(clk), .rst(rst), .agregar(agregar), .obtener(obtener),
    .puertas_m(puertas_m), .accion_m(accion_m), .piso_m(piso_m),
    .boton_pres(boton_pres), .memoria(memoria)
  );

  typedef struct {
    logic       rst;
    logic       ag;
    logic       ob;
    logic       pu;
    logic [1:0] ac;
    logic [1:0] pi;
    logic [3:0] bo;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t v(logic r, logic a, logic o, logic p,
                             logic [1:0] ac, logic [1:0] pi,
                             logic [3:0] bo, logic [3:0] e);
    vec_t t;
    t.rst = r; t.ag = a; t.ob = o; t.pu = p;
    t.ac = ac; t.pi = pi; t.bo = bo; t.exp = e;
    return t;
  endfunction

  task automatic check(string name, logic [3:0] got, logic [3:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: memoria=%0d expected=%0d", name, got, want);
    end else begin
      $display("ok   %s: memoria=%0d", name, got);
    end
  endtask

  initial begin
    //                  rst ag ob pu ac pi bo  exp
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0,  0)); // 0 reset
    vecs.push_back(v(1, 0, 1, 0, 0, 0, 0,  0)); // 1 empty
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 3,  0)); // 2 add 3
    vecs.push_back(v(1, 0, 1, 0, 1, 0, 0,  3)); // 3
    vecs.push_back(v(1, 0, 1, 0, 1, 0, 0,  3)); // 4 not cleared
    vecs.push_back(v(1, 0, 1, 1, 1, 2, 0,  0)); // 5 doors clear 3
    vecs.push_back(v(1, 0, 1, 0, 0, 0, 0,  0)); // 6
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 2,  0)); // 7
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 4,  0)); // 8
    vecs.push_back(v(1, 0, 1, 0, 1, 2, 0,  4)); // 9 up -> above
    vecs.push_back(v(1, 0, 1, 0, 2, 2, 0,  2)); // 10 down -> below
    vecs.push_back(v(1, 0, 1, 1, 0, 3, 0,  2)); // 11 clear 4
    vecs.push_back(v(1, 0, 1, 0, 0, 2, 0,  2)); // 12 idle {2}
    vecs.push_back(v(1, 0, 1, 1, 0, 1, 0,  0)); // 13 clear 2
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 7,  0)); // 14
    vecs.push_back(v(1, 0, 1, 0, 2, 1, 0,  0)); // 15 7 incompatible
    vecs.push_back(v(1, 0, 1, 0, 0, 1, 0,  7)); // 16 idle compatible
    vecs.push_back(v(1, 0, 1, 1, 0, 1, 0,  0)); // 17 clear 7
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 12, 0)); // 18 invalid
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 0,  0)); // 19 invalid
    vecs.push_back(v(1, 0, 1, 0, 0, 0, 0,  0)); // 20 still empty
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 8,  0)); // 21
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 9,  0)); // 22
    vecs.push_back(v(1, 0, 1, 0, 1, 0, 0,  9)); // 23 up before down
    vecs.push_back(v(1, 0, 1, 0, 2, 3, 0,  9)); // 24 below, up first
    vecs.push_back(v(1, 0, 1, 0, 2, 2, 0,  8)); // 25 here, down
    vecs.push_back(v(1, 0, 1, 0, 1, 2, 0,  9)); // 26 here, up
    vecs.push_back(v(1, 0, 1, 1, 2, 2, 0,  0)); // 27 clear 8 only
    vecs.push_back(v(1, 0, 1, 0, 0, 0, 0,  9)); // 28 9 kept
    vecs.push_back(v(1, 0, 1, 1, 3, 2, 0,  0)); // 29 accion 3 idle
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 1,  0)); // 30
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 10, 0)); // 31
    vecs.push_back(v(1, 0, 1, 0, 1, 1, 0, 10)); // 32
    vecs.push_back(v(1, 0, 1, 0, 2, 1, 0,  1)); // 33
    vecs.push_back(v(1, 0, 1, 0, 0, 1, 0, 10)); // 34
    vecs.push_back(v(1, 0, 1, 1, 0, 0, 0, 10)); // 35 clear 1
    vecs.push_back(v(1, 0, 1, 1, 2, 3, 0,  0)); // 36 clear 10
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 2,  0)); // 37
    vecs.push_back(v(1, 1, 1, 1, 0, 1, 2,  0)); // 38 clear then set
    vecs.push_back(v(1, 0, 1, 0, 0, 0, 0,  2)); // 39 bit 2 kept
    vecs.push_back(v(1, 1, 1, 0, 0, 0, 1,  2)); // 40 new 1 unseen
    vecs.push_back(v(1, 0, 1, 0, 0, 0, 0,  1)); // 41 now seen
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0,  0)); // 42 reset
    vecs.push_back(v(1, 0, 1, 0, 0, 0, 0,  0)); // 43 discarded

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; agregar = vecs[i].ag; obtener = vecs[i].ob;
      puertas_m = vecs[i].pu; accion_m = vecs[i].ac; piso_m = vecs[i].pi;
      boton_pres = vecs[i].bo;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), memoria, vecs[i].exp);
    end

    // Asynchronous reset mid-cycle must clear memoria without a clock edge.
    @(negedge clk);
    rst = 1'b1; agregar = 1'b1; obtener = 1'b0; boton_pres = 4'd4;
    @(negedge clk);
    agregar = 1'b0; obtener = 1'b1; puertas_m = 1'b0; accion_m = 2'd0; piso_m = 2'd0;
    @(posedge clk); #1;
    check("seq_pre_reset", memoria, 4'd4);
    #2 rst = 1'b0;
    #1;
    check("seq_async_reset", memoria, 4'd0);
    @(posedge clk); #1;
    check("seq_ignored_in_reset", memoria, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("seq_after_reset", memoria, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/manejo_memoria.md
Name: manejo_memoria

Overview:
- Pending-request memory for the 4-floor elevator controller.
- Latches button/hall-call codes presented on boton_pres when agregar is asserted.
- On obtener, computes the next instruction code for the elevator state machine from the current floor, direction and door state, and returns it on memoria.
- Sits beside the elevator state machine, which consumes memoria as its next-move command.

Parameters:
- none: 4 floors and 4-bit codes are fixed.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous active-low reset.
- agregar  input  1  store request: boton_pres is sampled on each rising clk while high.
- obtener  input  1  fetch request: the next instruction is computed and registered on each rising clk while high.
- puertas_m  input  1  current door state: 0 closed, 1 open.
- accion_m  input  2  current motion: 0 idle, 1 up, 2 down; 3 is treated as idle.
- piso_m  input  2  current floor index: 0..3 maps to floors 1..4.
- boton_pres  input  4  request code.
- memoria  output  4  registered next instruction code; 0 means no pending request.

Behaviour:
- Code map:
  - 1..4: cab call to floors 1..4.
  - 5: floor 1 up.
  - 6: floor 2 down. 7: floor 2 up.
  - 8: floor 3 down. 9: floor 3 up.
  - 10: floor 4 down.
  - Floor of a code is a 0..3 index: (c-1) for cab codes; 0/1/1/2/2/3 for codes 5..10.
- Storage: 10-bit pending vector, one bit per code 1..10.
- agregar=1 at a rising edge:
  - Sets the bit for boton_pres.
  - Codes 0 and 11..15 are ignored.
  - Setting an already-set bit has no effect.
- obtener=1 at a rising edge, evaluated in priority order. "Compatible" hall calls at the current floor are the up call if accion is up or idle, and the down call if accion is down or idle.
  1. If puertas_m=1, clear the cab bit and all compatible hall bits of floor piso_m. Selection below uses the vector after this clear.
  2. If puertas_m=0 and the current floor has a cab or compatible hall bit set, output it without clearing. Priority: cab, then same-direction hall, then other hall.
  3. If accion is up or idle and any request exists above piso_m, output a code of the nearest floor above. Within a floor: cab, then hall up, then hall down.
  4. Else if any request exists below piso_m, output a code of the nearest floor below, same within-floor priority.
  5. Else, if accion is down and requests exist above, output the nearest-above code.
  6. Else output 0.
- memoria updates one cycle after the obtener edge and holds its value until the next obtener edge.
- agregar and obtener asserted in the same cycle:
  - The clear from step 1 happens first, then the new set, so the new request is never lost.
  - The new request is not considered in that cycle's selection.
- obtener held high for multiple cycles re-evaluates every cycle; the result is idempotent while inputs are stable.
- Reset (rst=0, asynchronous): pending vector cleared, memoria=0.
  - Reset mid-operation discards all pending requests.
  - agregar and obtener are ignored while rst=0.

Test Plan:
- Reset, then obtener with piso_m=0, accion_m=0, puertas_m=0 -> memoria=0.
- agregar with boton_pres=3, then obtener at piso_m=0, accion_m=1, puertas_m=0 -> memoria=3. Repeat obtener -> memoria=3 (not cleared).
- Pending {3}, obtener at piso_m=2, puertas_m=1 -> bit cleared, memoria=0.
- Pending {2,4}, piso_m=2, accion_m=1, puertas_m=0 -> memoria=4.
  - Same with accion_m=2 -> memoria=2.
  - Idle, pending {2} only -> memoria=2.
- Pending {7}, piso_m=1, accion_m=2, puertas_m=0 -> 7 is not compatible, nothing below, step 5 -> memoria=0.
  - Same with accion_m=0 -> memoria=7.
  - agregar boton_pres=12 -> vector unchanged.
- Simultaneous: pending {2}, piso_m=1, puertas_m=1, agregar boton_pres=2 with obtener -> memoria=0, bit 2 remains set.
  - Then assert rst=0 mid-sequence -> memoria=0 immediately; next obtener -> 0.
